// File: rtl/fwd_pkg.sv
// Shared definitions for the distance-1 forwarding control unit and the
// execute-stage forwarding muxes that consume its select code.
package fwd_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 5;

  typedef enum logic [0:0] {
    FWD_IDLE      = 1'b0,
    FWD_LOAD_WAIT = 1'b1
  } fwd_state_e;

  // Forwarding mux select encoding: bit0 drives operand 1, bit1 operand 2.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_OP1  = 2'b01;
  localparam logic [1:0] FWD_OP2  = 2'b10;
  localparam logic [1:0] FWD_BOTH = 2'b11;

endpackage

// File: rtl/fwd_ctrl_unit_if.sv
// Pipeline-side bundle for the forwarding control unit: ID/EX/MEM observations
// in, forwarding selects, forwarded value and stall out.
interface fwd_ctrl_unit_if
  import fwd_pkg::*;
();

  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_is_load;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic [1:0]        cntrl_sign;
  logic [DATA_W-1:0] fwd_reg_val;
  logic              stall;

  modport master (
    output flush, id_valid, id_rs1, id_rs2, ex_valid, ex_rd, ex_reg_write,
           ex_is_load, ex_alu_result, mem_load_data,
    input  cntrl_sign, fwd_reg_val, stall
  );

  modport slave (
    input  flush, id_valid, id_rs1, id_rs2, ex_valid, ex_rd, ex_reg_write,
           ex_is_load, ex_alu_result, mem_load_data,
    output cntrl_sign, fwd_reg_val, stall
  );

endinterface

// File: rtl/fwd_match.sv
// Source-vs-destination comparator producing {rs2 match, rs1 match}, gated by
// a caller-supplied qualify bit.
module fwd_match
  import fwd_pkg::*;
(
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              qualify,
  output logic [1:0]        match
);

  assign match = {qualify & (rs2 == rd), qualify & (rs1 == rd)};

endmodule

// File: rtl/fwd_ctrl_unit.sv
// Distance-1 forwarding control: registered mux selects and forward value,
// plus a one-cycle load-use stall followed by forwarding of the load data.
module fwd_ctrl_unit
  import fwd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fwd_ctrl_unit_if.slave     bus
);

  fwd_state_e        state_q, state_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;
  logic [1:0]        cntrl_q, cntrl_d;
  logic [DATA_W-1:0] fwd_val_q, fwd_val_d;
  logic              stall_c;
  logic              ex_qual;
  logic              ld_qual;
  logic [1:0]        ex_m;
  logic [1:0]        ld_m;

  // x0 is never a producer, so rd==0 disqualifies the match outright.
  assign ex_qual = bus.id_valid & bus.ex_valid & bus.ex_reg_write & (bus.ex_rd != '0);
  assign ld_qual = bus.id_valid & (ld_rd_q != '0);

  fwd_match u_ex_match (
    .rs1     (bus.id_rs1),
    .rs2     (bus.id_rs2),
    .rd      (bus.ex_rd),
    .qualify (ex_qual),
    .match   (ex_m)
  );

  fwd_match u_ld_match (
    .rs1     (bus.id_rs1),
    .rs2     (bus.id_rs2),
    .rd      (ld_rd_q),
    .qualify (ld_qual),
    .match   (ld_m)
  );

  always_comb begin
    state_d   = state_q;
    ld_rd_d   = ld_rd_q;
    cntrl_d   = FWD_NONE;
    fwd_val_d = fwd_val_q;
    stall_c   = 1'b0;
    if (bus.flush) begin
      state_d = FWD_IDLE;
    end else begin
      unique case (state_q)
        FWD_IDLE: begin
          if (bus.ex_is_load && (ex_m != 2'b00)) begin
            // Load result not ready yet: hold ID, push a bubble into EX.
            stall_c = 1'b1;
            ld_rd_d = bus.ex_rd;
            state_d = FWD_LOAD_WAIT;
          end else begin
            cntrl_d = ex_m;
            if (ex_m != 2'b00) fwd_val_d = bus.ex_alu_result;
          end
        end
        FWD_LOAD_WAIT: begin
          cntrl_d   = ld_m;
          fwd_val_d = bus.mem_load_data;
          state_d   = FWD_IDLE;
        end
        default: state_d = FWD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FWD_IDLE;
      ld_rd_q   <= '0;
      cntrl_q   <= FWD_NONE;
      fwd_val_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      cntrl_q   <= cntrl_d;
      fwd_val_q <= fwd_val_d;
    end
  end

  assign bus.stall       = stall_c & ~rst;
  assign bus.cntrl_sign  = cntrl_q;
  assign bus.fwd_reg_val = fwd_val_q;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Directed bench for fwd_ctrl_unit: hand-computed selects, forward values and
// stall for ALU forwarding, load-use, x0, flush and reset-in-LOAD_WAIT cases.
module tb_fwd_ctrl_unit;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;

  fwd_ctrl_unit_if bus ();

  fwd_ctrl_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic fl, input logic idv,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic exv, input logic [4:0] rd,
                               input logic rw, input logic ld,
                               input logic [7:0] alu, input logic [7:0] mem);
    bus.flush         = fl;
    bus.id_valid      = idv;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.ex_valid      = exv;
    bus.ex_rd         = rd;
    bus.ex_reg_write  = rw;
    bus.ex_is_load    = ld;
    bus.ex_alu_result = alu;
    bus.mem_load_data = mem;
  endtask

  task automatic checkStall(input string tag, input logic exp_stall);
    n_compared++;
    assert (bus.stall === exp_stall)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s stall observed=%b expected=%b", tag, bus.stall, exp_stall);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] exp_cntrl,
                             input logic [7:0] exp_val);
    n_compared++;
    assert (bus.cntrl_sign === exp_cntrl)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s cntrl_sign observed=%b expected=%b", tag, bus.cntrl_sign, exp_cntrl);
    end
    n_compared++;
    assert (bus.fwd_reg_val === exp_val)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s fwd_reg_val observed=%h expected=%h", tag, bus.fwd_reg_val, exp_val);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;

    // Reset held with a load-use pattern on the inputs: stall must stay low.
    rst = 1'b1;
    applyStimulus(0, 1, 5'd7, 5'd0, 1, 5'd7, 1, 1, 8'h00, 8'h00);
    #2;
    checkStall("rst_stall", 1'b0);
    checkOutput("rst_out", 2'b00, 8'h00);
    @(posedge clk); #1;
    checkOutput("rst_out_edge", 2'b00, 8'h00);

    @(negedge clk);
    applyStimulus(0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 8'h00, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_after_rst", 2'b00, 8'h00);

    // ALU result of x3 forwarded to operand 1.
    @(negedge clk);
    applyStimulus(0, 1, 5'd3, 5'd4, 1, 5'd3, 1, 0, 8'h2A, 8'h00);
    #1 checkStall("alu_op1_stall", 1'b0);
    @(posedge clk); #1;
    checkOutput("alu_op1", 2'b01, 8'h2A);

    // Both sources match x5.
    @(negedge clk);
    applyStimulus(0, 1, 5'd5, 5'd5, 1, 5'd5, 1, 0, 8'h11, 8'h00);
    #1 checkStall("alu_both_stall", 1'b0);
    @(posedge clk); #1;
    checkOutput("alu_both", 2'b11, 8'h11);

    // No match: select drops to 00, value holds.
    @(negedge clk);
    applyStimulus(0, 1, 5'd1, 5'd2, 1, 5'd9, 1, 0, 8'h99, 8'h00);
    @(posedge clk); #1;
    checkOutput("no_match_hold", 2'b00, 8'h11);

    // Load x7 with consumer rs2=7: one stall cycle, bubble, then load data.
    @(negedge clk);
    applyStimulus(0, 1, 5'd1, 5'd7, 1, 5'd7, 1, 1, 8'h44, 8'h00);
    #1 checkStall("load_use_stall", 1'b1);
    @(posedge clk); #1;
    checkOutput("load_bubble", 2'b00, 8'h11);

    @(negedge clk);
    applyStimulus(0, 1, 5'd1, 5'd7, 0, 5'd0, 0, 0, 8'h00, 8'hC3);
    #1 checkStall("load_wait_stall", 1'b0);
    @(posedge clk); #1;
    checkOutput("load_fwd", 2'b10, 8'hC3);

    // x0 destination is never forwarded.
    @(negedge clk);
    applyStimulus(0, 1, 5'd0, 5'd3, 1, 5'd0, 1, 0, 8'h55, 8'h00);
    @(posedge clk); #1;
    checkOutput("x0_no_fwd", 2'b00, 8'hC3);

    // Invalid EX instruction with a matching rd.
    @(negedge clk);
    applyStimulus(0, 1, 5'd6, 5'd2, 0, 5'd6, 1, 0, 8'h66, 8'h00);
    @(posedge clk); #1;
    checkOutput("ex_invalid", 2'b00, 8'hC3);

    // Invalid ID instruction with a matching producer.
    @(negedge clk);
    applyStimulus(0, 0, 5'd6, 5'd6, 1, 5'd6, 1, 0, 8'h66, 8'h00);
    @(posedge clk); #1;
    checkOutput("id_invalid", 2'b00, 8'hC3);

    // Flush kills the load-use hazard; state must stay IDLE.
    @(negedge clk);
    applyStimulus(1, 1, 5'd8, 5'd1, 1, 5'd8, 1, 1, 8'h12, 8'h00);
    #1 checkStall("flush_stall", 1'b0);
    @(posedge clk); #1;
    checkOutput("flush_out", 2'b00, 8'hC3);

    // From IDLE an ALU producer forwards its result, not mem_load_data.
    @(negedge clk);
    applyStimulus(0, 1, 5'd8, 5'd1, 1, 5'd8, 1, 0, 8'h77, 8'hEE);
    #1 checkStall("post_flush_stall", 1'b0);
    @(posedge clk); #1;
    checkOutput("post_flush_idle", 2'b01, 8'h77);

    // Enter LOAD_WAIT, then reset asynchronously mid-wait.
    @(negedge clk);
    applyStimulus(0, 1, 5'd9, 5'd1, 1, 5'd9, 1, 1, 8'h00, 8'h00);
    #1 checkStall("load2_stall", 1'b1);
    @(posedge clk); #1;
    checkOutput("load2_bubble", 2'b00, 8'h77);

    @(negedge clk);
    applyStimulus(0, 1, 5'd9, 5'd1, 0, 5'd0, 0, 0, 8'h00, 8'hAB);
    rst = 1'b1;
    #1;
    checkStall("rst_wait_stall", 1'b0);
    checkOutput("rst_wait_async", 2'b00, 8'h00);
    @(posedge clk); #1;
    checkOutput("rst_wait_edge", 2'b00, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    #1 checkStall("rst_release_stall", 1'b0);
    @(posedge clk); #1;
    checkOutput("no_stale_fwd", 2'b00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
